// File: rtl/vx_dcache_req_arb.sv
// Per-lane round-robin arbiter sharing one data-cache request bus among several requester buses.
// Each output lane is a one-entry elastic register; the winning input index rides in the tag LSBs.
module vx_dcache_req_arb #(
  parameter  int NUM_INPUTS    = 2,
  parameter  int NUM_REQS      = 4,
  parameter  int WORD_SIZE     = 4,
  parameter  int ADDR_WIDTH    = 30,
  parameter  int TAG_IN_WIDTH  = 8,
  localparam int DW            = 8 * WORD_SIZE,
  localparam int IDX_WIDTH     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1,
  localparam int TAG_OUT_WIDTH = TAG_IN_WIDTH + IDX_WIDTH
) (
  input  logic                                        clk,
  input  logic                                        reset,
  input  logic [NUM_INPUTS*NUM_REQS-1:0]              in_valid,
  input  logic [NUM_INPUTS*NUM_REQS-1:0]              in_rw,
  input  logic [NUM_INPUTS*NUM_REQS*WORD_SIZE-1:0]    in_byteen,
  input  logic [NUM_INPUTS*NUM_REQS*ADDR_WIDTH-1:0]   in_addr,
  input  logic [NUM_INPUTS*NUM_REQS*DW-1:0]           in_data,
  input  logic [NUM_INPUTS*NUM_REQS*TAG_IN_WIDTH-1:0] in_tag,
  output logic [NUM_INPUTS*NUM_REQS-1:0]              in_ready,
  output logic [NUM_REQS-1:0]                         out_valid,
  output logic [NUM_REQS-1:0]                         out_rw,
  output logic [NUM_REQS*WORD_SIZE-1:0]               out_byteen,
  output logic [NUM_REQS*ADDR_WIDTH-1:0]              out_addr,
  output logic [NUM_REQS*DW-1:0]                      out_data,
  output logic [NUM_REQS*TAG_OUT_WIDTH-1:0]           out_tag,
  input  logic [NUM_REQS-1:0]                         out_ready
);

  localparam int NI = NUM_INPUTS;
  localparam int NR = NUM_REQS;

  logic [NR-1:0][IDX_WIDTH-1:0] ptr_q;
  logic [NR-1:0][IDX_WIDTH-1:0] grant_idx;
  logic [NR-1:0]                found;
  logic [NR-1:0]                free;
  logic [NR-1:0]                accept;
  logic [NR-1:0]                vld_q;
  int                           cand;

  // Priority search starts at the lane pointer and wraps modulo NI, so
  // indices >= NI are never produced even for non-power-of-two NI.
  always_comb begin
    // NOTE: every signal written here is defaulted first; a path that skips an
    // assignment would otherwise infer a latch.
    found     = '0;
    grant_idx = '0;
    in_ready  = '0;
    cand      = 0;
    free      = ~vld_q | out_ready;
    for (int j = 0; j < NR; j++) begin
      for (int k = 0; k < NI; k++) begin
        cand = int'(ptr_q[j]) + k;
        if (cand >= NI) cand = cand - NI;
        if (!found[j] && in_valid[cand*NR + j]) begin
          found[j]     = 1'b1;
          grant_idx[j] = IDX_WIDTH'(cand);
        end
      end
      for (int i = 0; i < NI; i++) begin
        in_ready[i*NR + j] = free[j] && found[j] && (grant_idx[j] == IDX_WIDTH'(i));
      end
    end
  end

  assign accept    = free & found;
  assign out_valid = vld_q;

  // NOTE: state registers use non-blocking assignments so every lane samples
  // the pre-edge values regardless of evaluation order.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_q <= '0;
      ptr_q <= '0;
    end else begin
      for (int j = 0; j < NR; j++) begin
        if (accept[j]) begin
          vld_q[j] <= 1'b1;
          ptr_q[j] <= (grant_idx[j] == IDX_WIDTH'(NI - 1)) ? '0
                                                           : grant_idx[j] + IDX_WIDTH'(1);
        end else if (out_ready[j]) begin
          vld_q[j] <= 1'b0;
        end
      end
    end
  end

  // NOTE: payload registers are deliberately left out of reset; they are only
  // meaningful while vld_q is set, and skipping reset keeps them plain flops.
  always_ff @(posedge clk) begin
    for (int j = 0; j < NR; j++) begin
      if (accept[j]) begin
        out_rw[j]                          <= in_rw[int'(grant_idx[j])*NR + j];
        out_byteen[j*WORD_SIZE +: WORD_SIZE] <=
          in_byteen[(int'(grant_idx[j])*NR + j)*WORD_SIZE +: WORD_SIZE];
        out_addr[j*ADDR_WIDTH +: ADDR_WIDTH] <=
          in_addr[(int'(grant_idx[j])*NR + j)*ADDR_WIDTH +: ADDR_WIDTH];
        out_data[j*DW +: DW] <= in_data[(int'(grant_idx[j])*NR + j)*DW +: DW];
        out_tag[j*TAG_OUT_WIDTH +: TAG_OUT_WIDTH] <=
          {in_tag[(int'(grant_idx[j])*NR + j)*TAG_IN_WIDTH +: TAG_IN_WIDTH], grant_idx[j]};
      end
    end
  end

endmodule

// File: doc/vx_dcache_req_arb.md
# vx_dcache_req_arb

Per-lane round-robin arbiter that shares one data-cache request bus among `NUM_INPUTS` requester buses of `NUM_REQS` lanes each. It sits between the core-side requesters (LSU, texture unit, raster/other memory clients) and the data cache's request slave port. Each output lane is driven from a one-entry elastic register. The winning input index is appended to the tag so the response path can route data back.

## Interface
Parameters:
- `NUM_INPUTS`, 2: number of requester buses sharing the cache port.
- `NUM_REQS`, 4: lanes per bus; arbitration is independent per lane.
- `WORD_SIZE`, 4: bytes per word; data width `DW` = 8*`WORD_SIZE`.
- `ADDR_WIDTH`, 30: word address width.
- `TAG_IN_WIDTH`, 8: requester tag width.
- `IDX_WIDTH`, derived: `clog2(NUM_INPUTS)`, minimum 1.
- `TAG_OUT_WIDTH`, derived: `TAG_IN_WIDTH` + `IDX_WIDTH`.

Ports (input buses flattened input-major: index = i*`NUM_REQS` + j):
- `clk`  in  1  clock; all state updates on its rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `in_valid`  in  `NUM_INPUTS`*`NUM_REQS`  per-lane request valid.
- `in_rw`  in  `NUM_INPUTS`*`NUM_REQS`  1 = write.
- `in_byteen`  in  `NUM_INPUTS`*`NUM_REQS`*`WORD_SIZE`  byte enables.
- `in_addr`  in  `NUM_INPUTS`*`NUM_REQS`*`ADDR_WIDTH`  word address.
- `in_data`  in  `NUM_INPUTS`*`NUM_REQS`*`DW`  write data.
- `in_tag`  in  `NUM_INPUTS`*`NUM_REQS`*`TAG_IN_WIDTH`  requester tag.
- `in_ready`  out  `NUM_INPUTS`*`NUM_REQS`  per-lane accept.
- `out_valid`  out  `NUM_REQS`  cache-side valid.
- `out_rw`, `out_byteen`, `out_addr`, `out_data`  out  `NUM_REQS` × field width  registered payload.
- `out_tag`  out  `NUM_REQS`*`TAG_OUT_WIDTH`  {`in_tag`, winning index}; index in LSBs.
- `out_ready`  in  `NUM_REQS`  cache-side accept.

## Operation
- Each lane j has a round-robin pointer `ptr[j]` (`IDX_WIDTH` bits) and an output register (`vld_q[j]` plus payload).
- Lane j is free when `vld_q[j]`=0 or `out_ready[j]`=1.
- Grant: the first input i, searching from `ptr[j]` upward modulo `NUM_INPUTS`, with `in_valid[i][j]`=1.
- `in_ready[i][j]` = free(j) AND grant(j)==i. It is 0 for all losers. It must not combinationally depend on the loser's own valid beyond the priority search.
- Acceptance (`in_valid` & `in_ready`): the register loads the payload and tag {`in_tag`, i}, `vld_q[j]` ← 1, and `ptr[j]` ← (i+1) mod `NUM_INPUTS`.
- When `out_ready[j]`=1 and there is no new acceptance, `vld_q[j]` ← 0.
- While `vld_q[j]`=1 and `out_ready[j]`=0, the output payload holds stable and the pointer holds.
- When the lane is free but nothing is valid on it, the pointer holds.
- Pointer wrap: (`NUM_INPUTS`-1)+1 → 0. For non-power-of-two `NUM_INPUTS`, index values ≥ `NUM_INPUTS` are never produced.
- When `NUM_INPUTS`=1, the index field is the constant 0 and the block is a pure per-lane register slice.
- Lanes are fully independent. Different inputs may win different lanes in the same cycle.

## Timing
- Reset (asynchronous assert, synchronous deassert by the integrator): `vld_q`=0, so `out_valid`=0; `ptr`=0. Output payload registers have don't-care reset values; the bench compares them only when `out_valid`=1.
- `in_ready` outputs are combinational. During reset they are 1 for the input-0 lanes only if `in_valid` is set there, but no acceptance occurs while reset is asserted.
- Latency: a request accepted at edge N appears on `out_valid` after edge N, i.e. 1 cycle.
- Throughput: 1 request per lane per cycle with continuous `out_ready`=1. No bubble on back-to-back requests.
- When `out_ready` and a new acceptance coincide, the register is replaced in the same edge and `out_valid` stays 1.
- Reset asserted mid-transfer drops any registered request. The requester must reissue.

## Test plan
- Reset: assert `reset`=0 with all `in_valid`=1 → `out_valid`=0 and `ptr`=0 after release. First grant per lane goes to input 0.
- Fairness, `NUM_INPUTS`=2, lane 0, both inputs valid continuously, `out_ready`=1 → grants alternate 0,1,0,1. `out_tag` LSB alternates the same way, with 1-cycle latency.
- Backpressure: input 1 lane 2 sends addr 0x100 and `out_ready[2]`=0 for 3 cycles → `out_valid[2]`=1 with addr 0x100 held stable. All `in_ready[*][2]`=0 until `out_ready[2]`=1.
- Lane independence: input 0 valid on lane 0 only, input 1 valid on lane 3 only, same cycle → both are accepted. The next cycle shows `out_valid`=4'b1001 with the correct tags.
- Wrap, `NUM_INPUTS`=3: only input 2 is valid, then all three are valid → pointer goes 2→0 and the next grant is input 0, then 1.
- Mid-flight reset: a request is registered with `out_ready`=0 and `reset` pulses low → `out_valid` drops immediately (asynchronously) and stays 0 after release until a new acceptance.
